// File: rtl/sc_collatz_monitor.sv
// Collatz sequence monitor.
// Captures a seed on start, then checks every change on the datapath bus
// against the Collatz rule (x/2 for even x, 3x+1 for odd x). It counts the
// accepted steps, keeps the peak value, and flags completion, overflow or
// an illegal transition. One registered value is routed to the display bus.
module sc_collatz_monitor #(
  parameter int DATAWIDTH_BUS               = 8,
  parameter int DATAWIDTH_DISPLAY_SELECTION = 2
) (
  input  logic                                   SC_COLLATZMONITOR_CLOCK_50,
  input  logic                                   SC_COLLATZMONITOR_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]               SC_COLLATZMONITOR_data_InBUS,
  input  logic                                   SC_COLLATZMONITOR_start_InHigh,
  input  logic [DATAWIDTH_DISPLAY_SELECTION-1:0] SC_COLLATZMONITOR_displayselection_InBUS,
  output logic [DATAWIDTH_BUS-1:0]               SC_COLLATZMONITOR_display_OutBUS,
  output logic                                   SC_COLLATZMONITOR_done_OutHigh,
  output logic                                   SC_COLLATZMONITOR_fault_OutHigh
);

  localparam int W  = DATAWIDTH_BUS;
  localparam int SW = DATAWIDTH_DISPLAY_SELECTION;

  // Small constants used in comparisons, sized to the bus.
  localparam logic [W-1:0]   ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   ALL1 = {W{1'b1}};
  // Largest value the bus can carry, in the widened arithmetic width.
  localparam logic [W+1:0]   MAXV = {2'b00, {W{1'b1}}};
  localparam logic [W+1:0]   ONEX = {{(W+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_prev;
  logic [W-1:0]   r_steps;
  logic [W-1:0]   r_peak;
  logic           r_ovf;
  logic           r_mis;
  logic           r_sat;
  logic           r_done;
  logic           r_fault;

  logic [W+1:0]   w_prev_ext;
  logic [W+1:0]   w_exp;
  logic [W+1:0]   w_data_ext;
  logic [W-1:0]   w_status;

  // Expected successor of the last accepted value, two bits wider so that
  // 3x+1 overflow of the bus width can be detected.
  always_comb begin
    w_prev_ext = {2'b00, r_prev};
    w_data_ext = {2'b00, SC_COLLATZMONITOR_data_InBUS};
    if (r_prev[0]) begin
      w_exp = (w_prev_ext << 1) + w_prev_ext + ONEX;
    end else begin
      w_exp = w_prev_ext >> 1;
    end
  end

  // Tracking FSM: seed capture, step checking, counters and sticky flags.
  always_ff @(posedge SC_COLLATZMONITOR_CLOCK_50) begin
    if (SC_COLLATZMONITOR_RESET_InHigh) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_steps <= '0;
      r_peak  <= '0;
      r_ovf   <= 1'b0;
      r_mis   <= 1'b0;
      r_sat   <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else if (SC_COLLATZMONITOR_start_InHigh) begin
      // A start always wins over a bus change: the bus value is the seed.
      r_prev  <= SC_COLLATZMONITOR_data_InBUS;
      r_peak  <= SC_COLLATZMONITOR_data_InBUS;
      r_steps <= '0;
      r_ovf   <= 1'b0;
      r_sat   <= 1'b0;
      if (SC_COLLATZMONITOR_data_InBUS > ONE) begin
        r_state <= TRACK;
        r_mis   <= 1'b0;
        r_done  <= 1'b0;
        r_fault <= 1'b0;
      end else if (SC_COLLATZMONITOR_data_InBUS == ONE) begin
        r_state <= DONE;
        r_mis   <= 1'b0;
        r_done  <= 1'b1;
        r_fault <= 1'b0;
      end else begin
        // A zero seed can never reach 1.
        r_state <= FAULT;
        r_mis   <= 1'b1;
        r_done  <= 1'b0;
        r_fault <= 1'b1;
      end
    end else begin
      case (r_state)
        TRACK: begin
          // An unchanged bus is the datapath holding its value: not a step.
          if (SC_COLLATZMONITOR_data_InBUS != r_prev) begin
            if (w_exp > MAXV) begin
              r_state <= FAULT;
              r_ovf   <= 1'b1;
              r_fault <= 1'b1;
            end else if (w_data_ext != w_exp) begin
              r_state <= FAULT;
              r_mis   <= 1'b1;
              r_fault <= 1'b1;
            end else begin
              r_prev <= SC_COLLATZMONITOR_data_InBUS;
              if (SC_COLLATZMONITOR_data_InBUS > r_peak) begin
                r_peak <= SC_COLLATZMONITOR_data_InBUS;
              end
              // Step counter saturates; sat records that it got there.
              if (r_steps != ALL1) begin
                r_steps <= r_steps + ONE;
                if ((r_steps + ONE) == ALL1) begin
                  r_sat <= 1'b1;
                end
              end
              if (SC_COLLATZMONITOR_data_InBUS == ONE) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        // IDLE, DONE and FAULT hold everything until start or reset.
        default: begin
        end
      endcase
    end
  end

  // Status word packed from the registered flags and state.
  always_comb begin
    w_status      = '0;
    w_status[7:0] = {r_done, r_fault, r_ovf, r_mis, r_sat, r_state, 1'b0};
  end

  // Display source mux: purely combinational over registered values.
  always_comb begin
    case (SC_COLLATZMONITOR_displayselection_InBUS)
      SW'(0):  SC_COLLATZMONITOR_display_OutBUS = r_prev;
      SW'(1):  SC_COLLATZMONITOR_display_OutBUS = r_steps;
      SW'(2):  SC_COLLATZMONITOR_display_OutBUS = r_peak;
      SW'(3):  SC_COLLATZMONITOR_display_OutBUS = w_status;
      default: SC_COLLATZMONITOR_display_OutBUS = '0;
    endcase
  end

  assign SC_COLLATZMONITOR_done_OutHigh  = r_done;
  assign SC_COLLATZMONITOR_fault_OutHigh = r_fault;

endmodule

// File: doc/sc_collatz_monitor.md
Name: sc_collatz_monitor

Overview:
- Downstream consumer of the uDATAPATH output bus in the Collatz system; sits between the datapath and the uo_out display pins.
- Captures the seed on a start pulse, then tracks every value change on the bus and checks that each change is a legal Collatz step (x/2 for even x, 3x+1 for odd x).
- Counts steps, records the peak value and flags completion, arithmetic overflow or illegal transitions.
- Drives one selectable 8-bit display word: current value, step count, peak or status.

Parameters:
- DATAWIDTH_BUS, 8, width of the data bus, step counter, peak register and display word; must be >= 8.
- DATAWIDTH_DISPLAY_SELECTION, 2, width of the display select input.

Ports:
- SC_COLLATZMONITOR_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SC_COLLATZMONITOR_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_COLLATZMONITOR_data_InBUS  in  DATAWIDTH_BUS  value currently presented by uDATAPATH.
- SC_COLLATZMONITOR_start_InHigh  in  1  one-cycle pulse meaning the data bus now holds a new seed.
- SC_COLLATZMONITOR_displayselection_InBUS  in  DATAWIDTH_DISPLAY_SELECTION  display source select.
- SC_COLLATZMONITOR_display_OutBUS  out  DATAWIDTH_BUS  selected display word.
- SC_COLLATZMONITOR_done_OutHigh  out  1  sequence reached 1.
- SC_COLLATZMONITOR_fault_OutHigh  out  1  overflow or illegal transition detected.

Behaviour:
- Internal registers:
  - prev: last accepted value.
  - steps: step counter.
  - peak: maximum accepted value.
  - state, one of IDLE=0, TRACK=1, DONE=2, FAULT=3.
  - sticky flags ovf, mis, sat.
- Reset (synchronous, active-high): all registers 0, state IDLE, done=0, fault=0. With select=00 the display reads 0. Reset has priority over start and over everything else. Reset mid-sequence discards all progress.
- Start (any state, when reset is low): on that edge:
  - prev <= data, peak <= data, steps <= 0, ovf/mis/sat <= 0.
  - Next state TRACK if data > 1; DONE if data == 1; FAULT with mis=1 if data == 0.
- TRACK, per cycle without start:
  - data == prev: hold; no count, no check. The datapath may hold a value for any number of cycles.
  - data != prev: compute exp = prev[0] ? 3*prev+1 : prev>>1 in DATAWIDTH_BUS+2 bits.
    - exp > 2^DATAWIDTH_BUS-1: go to FAULT, set ovf=1; steps, peak and prev unchanged.
    - Else if data != exp: go to FAULT, set mis=1; steps, peak and prev unchanged.
    - Else accept the step:
      - prev <= data; peak <= max(peak, data).
      - steps <= steps+1, saturating at all-ones; reaching all-ones sets sat=1 and tracking continues.
      - If data == 1, go to DONE.
- DONE and FAULT: hold all registers until start or reset; bus changes are ignored.
- done = (state == DONE); fault = (state == FAULT). Both registered, valid the cycle after the deciding edge.
- Latency: the step that moves the bus to value v is reflected in steps, peak, state and flags after exactly one clock edge.
- Display (combinational mux of registered values, no added latency):
  - 00: prev.
  - 01: steps.
  - 10: peak.
  - 11: status = {done, fault, ovf, mis, sat, state[1:0], 0}, upper bits zero if DATAWIDTH_BUS > 8.
- Simultaneous events:
  - Start and a bus change in the same cycle: start wins; the bus value is taken as the seed.
  - Reset and start together: reset wins.

Test Plan:
- Seed 6 via start, bus walks 6,3,10,5,16,8,4,2,1, one value per cycle -> done=1, fault=0, steps=8, peak=16, status=0x84 (state DONE).
- Seed 27, legal steps through 107, then bus shows 66 (322 mod 256) -> FAULT, ovf=1, steps=11, peak=214, prev=107, fault=1.
- Seed 6, bus jumps to 4 -> FAULT, mis=1, steps=0, peak=6. Separately, seed 1 -> DONE, steps=0. Seed 0 -> FAULT, mis=1.
- Seed 6 with each value held 3 cycles -> steps=8, same as the unheld run. Mid-run (bus=5) assert reset one cycle -> all outputs 0, state IDLE, further bus changes ignored.
- While in DONE, start with bus=7 -> state TRACK, steps=0, peak=7, done=0. The 7→...→1 walk (16 steps, peak 52) ends in DONE, steps=16.
- Start asserted in the same cycle the bus changes -> new value taken as seed, no fault. Display select cycled 00..11 returns prev, steps, peak and status with no cycle delay.
